serial_sub: RTL
===============

Name: serial_sub

Overview:
- Bit-serial subtractor computing diff = a - b, LSB first, one bit per clock.
- Built from a single full-adder slice, a carry/borrow flip-flop and operand shift registers: a + ~b + 1.
- The inverse operation to the combinational HA2/FA2 adder cells; a low-area arithmetic engine for the ALU datapath.
- Start/busy/done handshake toward the ALU sequencer.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk only while busy=0
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse, results valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when unsigned a < b
- ovf  output  1  signed two's-complement overflow
- zero  output  1  1 when diff == 0

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, zero=0, bit counter=0, carry FF=0.
- States:
  - IDLE -> RUN on start=1 at edge E0. Capture a, b into shift registers; carry FF=1; counter=0; busy=1.
  - RUN: each edge computes s = a_sh[0] ^ ~b_sh[0] ^ c, shifts s into the result register MSB-first-in, updates c, shifts both operands right, counter+1.
  - At edge E0+WIDTH the last bit is processed. diff, borrow, ovf and zero load simultaneously; busy=0; done=1; state -> DONE.
  - DONE: one cycle only, then -> IDLE with done=0. start=1 during DONE (busy=0) is accepted: -> RUN, back-to-back operation, no idle gap.
- Latency: done is visible WIDTH cycles after the accepting edge. Throughput: one result per WIDTH+1 cycles when back-to-back (DONE cycle doubles as the next accept).
- Flags:
  - borrow = ~carry_out.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operands.
  - zero = (diff == 0).
- Output hold: diff and flags update only at the completing edge and hold until the next completion or reset. Internal shift registers are not exposed.
- start while busy=1: ignored, with no effect on the running operation and no queuing.
- a and b may change freely after the accepting edge.
- Reset asserted mid-operation: abort immediately to reset values. No done pulse for the aborted operation.
- Counter width is $clog2(WIDTH)+1. Terminal count is WIDTH-1; no wrap-around beyond it.

Optional Feature:
- Macro SERIAL_SUB_ADD_EN.
- Defined: adds input port op (1 bit), captured with a and b on the accepting edge.
  - op=0: subtract, exactly as above.
  - op=1: add. b is not inverted, initial carry FF=0, borrow port carries the raw carry-out (unsigned overflow). ovf uses the add rule: (a[MSB]==b[MSB]) && (diff[MSB]!=a[MSB]).
- Undefined: no op port; subtract only.

Test Plan (WIDTH=8):
- Reset release, a=0x05, b=0x03, start pulse at E0 -> busy=1 from E0. At E0+8: done=1 for exactly 1 cycle, diff=0x02, borrow=0, ovf=0, zero=0, busy=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0, zero=0.
- a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Then a=0x2A, b=0x2A started in the DONE cycle -> accepted with no gap, diff=0x00, zero=1, borrow=0.
- Start 0x10-0x01; pulse start again with a=0xFF, b=0x00 at E0+3 -> ignored; result diff=0x0F at E0+8, no extra done.
- Start 0x10-0x01; assert rst_n=0 at E0+4 -> all outputs 0 immediately, no done pulse; after release, 0x09-0x04 completes normally with diff=0x05.
- SERIAL_SUB_ADD_EN defined, op=1, a=0xFF, b=0x01 -> diff=0x00, borrow(carry)=1, zero=1, ovf=0. Then op=1, a=0x7F, b=0x01 -> diff=0x80, ovf=1.

Source files
------------

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/busy/done operand and result bundle for serial_sub (op port under SERIAL_SUB_ADD_EN)
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADD_EN
    logic             op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output start,
        output a,
        output b,
`ifdef SERIAL_SUB_ADD_EN
        output op,
`endif
        input  busy,
        input  done,
        input  diff,
        input  borrow,
        input  ovf,
        input  zero
    );

    modport slave (
        input  start,
        input  a,
        input  b,
`ifdef SERIAL_SUB_ADD_EN
        input  op,
`endif
        output busy,
        output done,
        output diff,
        output borrow,
        output ovf,
        output zero
    );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial a-b (a+~b+1) engine, LSB first; SERIAL_SUB_ADD_EN adds an op input selecting a+b
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, ovf_q, zero_q;

    logic             accept, last;
    logic             sub_mode, carry_init;
    logic             b_bit, sum, cout;
    logic [WIDTH-1:0] res_nx;

`ifdef SERIAL_SUB_ADD_EN
    logic             op_q;
    assign sub_mode   = ~op_q;
    assign carry_init = ~bus.op;
`else
    assign sub_mode   = 1'b1;
    assign carry_init = 1'b1;
`endif

    // DONE shows busy=0, so a start there begins the next operation with no gap
    assign accept = (state != RUN) && bus.start;
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    assign b_bit  = sub_mode ? ~b_sh[0] : b_sh[0];
    assign sum    = a_sh[0] ^ b_bit ^ carry;
    assign cout   = (a_sh[0] & b_bit) | (a_sh[0] & carry) | (b_bit & carry);
    assign res_nx = {sum, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
            op_q     <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= carry_init;
            cnt   <= '0;
`ifdef SERIAL_SUB_ADD_EN
            op_q  <= bus.op;
`endif
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nx;
            carry  <= cout;
            if (!last) begin
                cnt <= cnt + CW'(1);
            end else begin
                // On the last bit a_sh[0]/b_sh[0] are the captured operand sign bits
                diff_q   <= res_nx;
                borrow_q <= sub_mode ? ~cout : cout;
                ovf_q    <= sub_mode ? ((a_sh[0] != b_sh[0]) && (sum != a_sh[0]))
                                     : ((a_sh[0] == b_sh[0]) && (sum != a_sh[0]));
                zero_q   <= (res_nx == '0);
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule
